// File: rtl/imem_boot_fetch.sv
// Boot-loadable instruction memory: words are streamed in during LOAD, then
// served to the fetch stage with one-cycle latency and misaligned/out-of-range faulting.
module imem_boot_fetch #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 1024,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       boot_start,
  input  logic                       ld_valid,
  input  logic [XLEN-1:0]            ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic [$clog2(DEPTH):0]     ld_count,
  output logic                       boot_done,
  input  logic [31:0]                A,
  input  logic                       req,
  input  logic                       stall,
  output logic [XLEN-1:0]            RD,
  output logic                       rd_valid,
  output logic                       fault
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state, state_next;
  logic            wr_en;
  logic            fault_p0;
  logic [AW-1:0]   word_idx_p0;

  // Storage keeps its contents across reset and reboot; power-up contents are zero.
  logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

  assign ld_ready  = (state == LOAD);
  assign boot_done = (state == RUN);

  // Fetch decode stage: address checks happen before the read register.
  assign word_idx_p0 = A[AW+1:2];
  assign fault_p0    = (A[1:0] != 2'b00) || (A[31:AW+2] != '0);

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      IDLE: if (boot_start) state_next = LOAD;
      LOAD: begin
        // A restart request wins over a simultaneous load word.
        if (!boot_start && ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || ld_count == LAST_IDX) state_next = RUN;
        end
      end
      RUN:  if (boot_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ld_count <= '0;
    end else begin
      state <= state_next;
      if (boot_start)  ld_count <= '0;
      else if (wr_en)  ld_count <= ld_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_count[AW-1:0]] <= ld_data;
  end

  // Fetch result stage: outputs frozen under stall, cleared outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD       <= '0;
      rd_valid <= 1'b0;
      fault    <= 1'b0;
    end else if (state != RUN || boot_start) begin
      rd_valid <= 1'b0;
      fault    <= 1'b0;
    end else if (!stall) begin
      if (req) begin
        rd_valid <= 1'b1;
        fault    <= fault_p0;
        RD       <= fault_p0 ? NOP : mem[word_idx_p0];
      end else begin
        rd_valid <= 1'b0;
        fault    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Directed bench for imem_boot_fetch: boot load, fetch, stall, fault, restart
// and reset scenarios on a DEPTH=1024 instance plus a DEPTH=4 overflow case.
module tb_imem_boot_fetch;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=1024 instance signals
  logic        boot_start = 0, ld_valid = 0, ld_last = 0, req = 0, stall = 0;
  logic [31:0] ld_data = 0, A = 0;
  logic        ld_ready, boot_done, rd_valid, fault;
  logic [10:0] ld_count;
  logic [31:0] rd;

  // DEPTH=4 instance signals
  logic        boot_start4 = 0, ld_valid4 = 0, ld_last4 = 0, req4 = 0, stall4 = 0;
  logic [31:0] ld_data4 = 0, a4 = 0;
  logic        ld_ready4, boot_done4, rd_valid4, fault4;
  logic [2:0]  ld_count4;
  logic [31:0] rd4;

  imem_boot_fetch #(.XLEN(32), .DEPTH(1024), .NOP(NOPW)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_count(ld_count), .boot_done(boot_done), .A(A), .req(req),
    .stall(stall), .RD(rd), .rd_valid(rd_valid), .fault(fault)
  );

  imem_boot_fetch #(.XLEN(32), .DEPTH(4), .NOP(NOPW)) dut4 (
    .clk(clk), .rst(rst), .boot_start(boot_start4), .ld_valid(ld_valid4),
    .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
    .ld_count(ld_count4), .boot_done(boot_done4), .A(a4), .req(req4),
    .stall(stall4), .RD(rd4), .rd_valid(rd_valid4), .fault(fault4)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model  [1024];
  logic [31:0] model4 [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch, queue the model's prediction, and retire it on the result cycle.
  task automatic fetch(input bit on4, input logic [31:0] addr, input string tag);
    exp_t e;
    logic f;
    f = (addr[1:0] != 2'b00) || (on4 ? (addr >= 32'd16) : (addr >= 32'd4096));
    e.flt = f;
    e.rd  = f ? NOPW : (on4 ? model4[addr[3:2]] : model[addr[11:2]]);
    exp_q.push_back(e);
    if (on4) begin a4 = addr; req4 = 1; stall4 = 0; end
    else     begin A  = addr; req  = 1; stall  = 0; end
    step();
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_vld"},   {31'd0, on4 ? rd_valid4 : rd_valid}, 32'd1);
      check({tag, "_rd"},    on4 ? rd4 : rd, e.rd);
      check({tag, "_fault"}, {31'd0, on4 ? fault4 : fault}, {31'd0, e.flt});
    end
    if (on4) req4 = 0; else req = 0;
  endtask

  logic [31:0] prog [4];

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) model4[i] = '0;
    prog[0] = 32'h00A0_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0010_0193; prog[3] = 32'h0020_8863;

    // Reset state
    #1 rst = 1;
    #1;
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_ld_count", {21'd0, ld_count}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    step(); step();
    rst = 0;

    // IDLE ignores req
    A = 32'h8; req = 1;
    step();
    check("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
    req = 0;

    // Boot load of four words
    boot_start = 1;
    step();
    boot_start = 0;
    check("load_ready", {31'd0, ld_ready}, 32'd1);
    check("load_count0", {21'd0, ld_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = prog[i]; ld_last = (i == 3);
      model[i] = prog[i];
      req = 1; A = 32'h0;
      step();
      if (i < 3) check("load_no_fetch", {31'd0, rd_valid}, 32'd0);
    end
    ld_valid = 0; ld_last = 0; req = 0;
    check("load_count4", {21'd0, ld_count}, 32'd4);
    check("load_boot_done", {31'd0, boot_done}, 32'd1);
    check("load_ready_off", {31'd0, ld_ready}, 32'd0);

    fetch(0, 32'h8, "fetch8");

    // Stall holds outputs
    fetch(0, 32'h4, "fetch4");
    for (int i = 0; i < 3; i++) begin
      stall = 1; req = 1; A = 32'hC;
      step();
      check("stall_rd", rd, 32'h00A0_0113);
      check("stall_vld", {31'd0, rd_valid}, 32'd1);
    end
    stall = 0; req = 0;
    fetch(0, 32'hC, "fetchC");

    // Idle cycle in RUN clears valid, keeps RD
    step();
    check("idle_clr_vld", {31'd0, rd_valid}, 32'd0);
    check("idle_keep_rd", rd, 32'h0020_8863);

    // Faulting fetches, then a stalled fault holds
    fetch(0, 32'h2, "fault_mis");
    fetch(0, 32'h1000, "fault_range");
    stall = 1; req = 1; A = 32'h0;
    step();
    check("stall_fault", {31'd0, fault}, 32'd1);
    stall = 0; req = 0;
    fetch(0, 32'hFFC, "unwritten");

    // boot_start in RUN
    req = 1; A = 32'h0;
    step();
    boot_start = 1;
    step();
    boot_start = 0; req = 0;
    check("reboot_ready", {31'd0, ld_ready}, 32'd1);
    check("reboot_vld", {31'd0, rd_valid}, 32'd0);
    check("reboot_count", {21'd0, ld_count}, 32'd0);

    // One write, then restart colliding with ld_valid
    ld_valid = 1; ld_data = 32'hDEAD_0001; model[0] = 32'hDEAD_0001;
    step();
    check("restart_pre", {21'd0, ld_count}, 32'd1);
    boot_start = 1; ld_data = 32'hBEEF_0002;
    step();
    boot_start = 0;
    check("restart_count", {21'd0, ld_count}, 32'd0);

    // Two words then asynchronous reset mid-load
    ld_data = 32'h1111_1111; model[0] = 32'h1111_1111;
    step();
    ld_data = 32'h2222_2222; model[1] = 32'h2222_2222;
    step();
    ld_valid = 0;
    check("midload_count", {21'd0, ld_count}, 32'd2);
    #2 rst = 1;
    #1;
    check("async_count", {21'd0, ld_count}, 32'd0);
    check("async_ready", {31'd0, ld_ready}, 32'd0);
    step();
    rst = 0;
    boot_start = 1;
    step();
    boot_start = 0;
    ld_valid = 1; ld_last = 1; ld_data = 32'h3333_3333; model[0] = 32'h3333_3333;
    step();
    ld_valid = 0; ld_last = 0;
    check("reload_done", {31'd0, boot_done}, 32'd1);
    check("reload_count", {21'd0, ld_count}, 32'd1);
    fetch(0, 32'h4, "kept_word1");
    fetch(0, 32'h0, "new_word0");

    // DEPTH=4: six words streamed without ld_last
    boot_start4 = 1;
    step();
    boot_start4 = 0;
    for (int i = 0; i < 6; i++) begin
      ld_valid4 = 1; ld_data4 = 32'hA000_0000 + i;
      if (i < 4) model4[i] = 32'hA000_0000 + i;
      step();
      if (i == 2) check("d4_not_done", {31'd0, boot_done4}, 32'd0);
    end
    ld_valid4 = 0;
    check("d4_count", {29'd0, ld_count4}, 32'd4);
    check("d4_done", {31'd0, boot_done4}, 32'd1);
    for (int i = 0; i < 4; i++) fetch(1, 32'(i * 4), "d4_word");
    fetch(1, 32'h10, "d4_range");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
